// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying {pc, inst} between two stages over a valid/ready
// handshake. A two-entry skid buffer keeps in_ready registered, and the stage supports flush and kill-next.
module pipe_stage_reg #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned KILL_NEXT   = 1,
    parameter int unsigned ZERO_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              flush,
    output logic              kill_pend,
    output logic [1:0]        occupancy
);

    logic              m_v_q, m_v_d, s_v_q, s_v_d, kill_q, kill_d;
    logic [ADDR_W-1:0] m_pc_q, m_pc_d, s_pc_q, s_pc_d;
    logic [INST_W-1:0] m_inst_q, m_inst_d, s_inst_q, s_inst_d;
    logic              acc_s, drn_s, discard_s, st_s;

    // in_ready depends only on the skid flag, so there is no combinational path from out_ready
    assign in_ready  = rst & ~s_v_q;
    assign out_valid = m_v_q;
    assign kill_pend = kill_q;
    assign occupancy = {1'b0, m_v_q} + {1'b0, s_v_q};
    assign out_pc    = ((ZERO_BUBBLE != 0) && !m_v_q) ? {ADDR_W{1'b0}} : m_pc_q;
    assign out_inst  = ((ZERO_BUBBLE != 0) && !m_v_q) ? {INST_W{1'b0}} : m_inst_q;

    assign acc_s     = in_valid & in_ready;
    assign drn_s     = m_v_q & out_ready;
    assign discard_s = acc_s & kill_q;
    assign st_s      = acc_s & ~discard_s & ~flush;

    // Next-state selection for the main/skid entries and the pending-kill flag
    always_comb begin
        m_v_d    = m_v_q;
        m_pc_d   = m_pc_q;
        m_inst_d = m_inst_q;
        s_v_d    = s_v_q;
        s_pc_d   = s_pc_q;
        s_inst_d = s_inst_q;
        kill_d   = kill_q;
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
            if (ZERO_BUBBLE != 0) begin
                m_pc_d   = {ADDR_W{1'b0}};
                m_inst_d = {INST_W{1'b0}};
                s_pc_d   = {ADDR_W{1'b0}};
                s_inst_d = {INST_W{1'b0}};
            end else begin
                m_pc_d   = m_pc_q;
                m_inst_d = m_inst_q;
            end
            // A wrong-path beat is still upstream unless it was just accepted and dropped here
            if (KILL_NEXT != 0) begin
                kill_d = ~acc_s;
            end else begin
                kill_d = 1'b0;
            end
        end else begin
            if (discard_s) begin
                kill_d = 1'b0;
            end else begin
                kill_d = kill_q;
            end
            if (!m_v_q || drn_s) begin
                if (s_v_q) begin
                    m_v_d    = 1'b1;
                    m_pc_d   = s_pc_q;
                    m_inst_d = s_inst_q;
                    if (st_s) begin
                        s_pc_d   = in_pc;
                        s_inst_d = in_inst;
                    end else begin
                        s_v_d = 1'b0;
                    end
                end else if (st_s) begin
                    m_v_d    = 1'b1;
                    m_pc_d   = in_pc;
                    m_inst_d = in_inst;
                end else begin
                    m_v_d = 1'b0;
                end
            end else if (st_s) begin
                s_v_d    = 1'b1;
                s_pc_d   = in_pc;
                s_inst_d = in_inst;
            end else begin
                s_v_d = s_v_q;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_v_q    <= 1'b0;
            s_v_q    <= 1'b0;
            kill_q   <= 1'b0;
            m_pc_q   <= {ADDR_W{1'b0}};
            m_inst_q <= {INST_W{1'b0}};
            s_pc_q   <= {ADDR_W{1'b0}};
            s_inst_q <= {INST_W{1'b0}};
        end else begin
            m_v_q    <= m_v_d;
            s_v_q    <= s_v_d;
            kill_q   <= kill_d;
            m_pc_q   <= m_pc_d;
            m_inst_q <= m_inst_d;
            s_pc_q   <= s_pc_d;
            s_inst_q <= s_inst_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a default build and a KILL_NEXT=0 / ZERO_BUBBLE=0 build
// share one stimulus stream and are each checked against a FIFO-level reference model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_inst = 32'd0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;

    logic        rdy [2];
    logic        vld [2];
    logic [31:0] opc [2];
    logic [31:0] oinst [2];
    logic        kp [2];
    logic [1:0]  occ [2];

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] q [2][$];
    logic [31:0] seen [2][$];
    logic        kill [2];
    int          psz [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.ADDR_W(32), .INST_W(32), .KILL_NEXT(1), .ZERO_BUBBLE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_pc(in_pc),
        .in_inst(in_inst), .out_valid(vld[0]), .out_ready(out_ready), .out_pc(opc[0]),
        .out_inst(oinst[0]), .flush(flush), .kill_pend(kp[0]), .occupancy(occ[0])
    );

    pipe_stage_reg #(.ADDR_W(32), .INST_W(32), .KILL_NEXT(0), .ZERO_BUBBLE(0)) u_dut_k0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_pc(in_pc),
        .in_inst(in_inst), .out_valid(vld[1]), .out_ready(out_ready), .out_pc(opc[1]),
        .out_inst(oinst[1]), .flush(flush), .kill_pend(kp[1]), .occupancy(occ[1])
    );

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    function automatic bit seen_has(input int k, input logic [31:0] pc);
        for (int i = 0; i < seen[k].size(); i++) begin
            if (seen[k][i] == pc) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference model: a 2-deep FIFO plus a kill flag, updated on each rising edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                q[k].delete();
                kill[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit acc;
                acc = in_valid && (psz[k] < 2);
                if (flush) begin
                    q[k].delete();
                    kill[k] = (k == 0) ? !acc : 1'b0;
                end else if (acc && kill[k]) begin
                    kill[k] = 1'b0;
                end else if (acc) begin
                    q[k].push_back({in_pc, in_inst});
                end
            end
        end
    end

    // Monitor: compare every output on the falling edge and pop beats taken downstream
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int sz;
            sz = q[k].size();
            psz[k] = sz;
            chk("in_ready", k, {63'd0, rdy[k]}, {63'd0, (rst && sz < 2)});
            chk("out_valid", k, {63'd0, vld[k]}, {63'd0, (sz > 0)});
            chk("occupancy", k, {62'd0, occ[k]}, sz);
            chk("kill_pend", k, {63'd0, kp[k]}, {63'd0, kill[k]});
            if (sz > 0) begin
                chk("out_pc", k, {32'd0, opc[k]}, {32'd0, q[k][0][63:32]});
                chk("out_inst", k, {32'd0, oinst[k]}, {32'd0, q[k][0][31:0]});
                if (out_ready) begin
                    seen[k].push_back(q[k][0][63:32]);
                    void'(q[k].pop_front());
                end
            end else if (k == 0) begin
                chk("bubble_pc", k, {32'd0, opc[k]}, 64'd0);
                chk("bubble_inst", k, {32'd0, oinst[k]}, 64'd0);
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = $urandom;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // Streaming at full rate
        cyc(1'b1, 32'h100, 1'b1, 1'b0);
        cyc(1'b1, 32'h104, 1'b1, 1'b0);
        cyc(1'b1, 32'h108, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        // Backpressure fills the skid, then drains in order
        cyc(1'b1, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 1'b0, 1'b0);
        cyc(1'b1, 32'h208, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        // Flush with both entries full and no accept arms the kill
        cyc(1'b1, 32'h300, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h400, 1'b1, 1'b0);
        cyc(1'b1, 32'h500, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        // Flush with a concurrent accept drops that beat and leaves no kill
        cyc(1'b1, 32'h600, 1'b1, 1'b1);
        cyc(1'b1, 32'h604, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("dropped_400_absent", 0, {63'd0, seen_has(0, 32'h400)}, 64'd0);
        chk("kept_400_present", 1, {63'd0, seen_has(1, 32'h400)}, 64'd1);
        chk("pc_500_present", 0, {63'd0, seen_has(0, 32'h500)}, 64'd1);
        chk("dropped_600_absent", 0, {63'd0, seen_has(0, 32'h600)}, 64'd0);
        chk("dropped_600_absent", 1, {63'd0, seen_has(1, 32'h600)}, 64'd0);
        chk("pc_604_present", 0, {63'd0, seen_has(0, 32'h604)}, 64'd1);
        // Asynchronous reset between edges while stalled and full
        cyc(1'b1, 32'h7f0, 1'b0, 1'b0);
        cyc(1'b1, 32'h7f4, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, {63'd0, vld[k]}, 64'd0);
            chk("rst_in_ready", k, {63'd0, rdy[k]}, 64'd0);
            chk("rst_occupancy", k, {62'd0, occ[k]}, 64'd0);
            chk("rst_out_pc", k, {32'd0, opc[k]}, 64'd0);
            chk("rst_out_inst", k, {32'd0, oinst[k]}, 64'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(1'b1, 32'h700, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pc_700_present", 0, {63'd0, seen_has(0, 32'h700)}, 64'd1);
        chk("pc_7f0_absent", 0, {63'd0, seen_has(0, 32'h7f0)}, 64'd0);
        // Randomised traffic with backpressure and occasional flushes
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), {$urandom_range(0, 32'hffff), 2'b00} | 32'h1_0000_0,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed IF/ID latch: a pipeline stage register carrying {pc, inst} between any two pipeline stages.
- Replaces the stall-vector interface with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Supports flush, an optional deferred kill of the next in-flight beat, and optional zeroed bubbles (NOP insertion).

Parameters:
ADDR_W, 32, pc width in bits
INST_W, 32, instruction/payload width in bits
KILL_NEXT, 1, 1 = a flush with no beat accepted that cycle arms kill_pend; 0 = the flush clears storage only
ZERO_BUBBLE, 1, 1 = out_pc/out_inst driven to 0 whenever out_valid=0; 0 = hold the last value

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_pc  in  ADDR_W  upstream pc
in_inst  in  INST_W  upstream instruction
out_valid  out  1  beat present at output
out_ready  in  1  downstream accepts the beat
out_pc  out  ADDR_W  output pc
out_inst  out  INST_W  output instruction
flush  in  1  branch/redirect flush, sampled at posedge
kill_pend  out  1  next accepted beat will be discarded
occupancy  out  2  number of valid entries, 0..2

Behaviour:
- Storage:
  - main entry (m_v, m_pc, m_inst) drives the outputs.
  - skid entry (s_v, s_pc, s_inst) holds overflow.
- Reset (rst=0, asynchronous):
  - m_v=s_v=0, all payload regs=0, kill_pend=0.
  - out_valid=0, out_pc=0, out_inst=0, occupancy=0.
  - in_ready forced 0 while rst=0.
  - Operation resumes on the first posedge after rst rises.
  - Reset mid-transfer discards all held beats.
- Combinational:
  - in_ready = !s_v (a function of a register only; no path from out_ready).
  - out_valid = m_v.
  - occupancy = m_v + s_v.
- Accept: acc = in_valid & in_ready.
- Drain: drn = m_v & out_ready.
- Kill: discard = acc & kill_pend.
  - The discarded beat is consumed upstream (handshake completes) but is never stored.
  - kill_pend clears on the same edge.
- Store: st = acc & !discard & !flush.
- Per posedge, no flush:
  - m_v=0 or drn, with s_v=1: main<=skid; skid<=incoming if st, else s_v<=0.
  - m_v=0 or drn, with s_v=0: main<=incoming if st, else m_v<=0.
  - m_v=1, !drn, with st: skid<=incoming (s_v was 0 because in_ready=1).
  - m_v=1, !drn, without st: hold.
- Ordering is strict FIFO: main is always older than skid.
- Flush (highest priority after reset):
  - m_v<=0, s_v<=0; payload regs<=0 when ZERO_BUBBLE=1.
  - A beat accepted in the same cycle is dropped.
  - A beat being drained in the same cycle still completes downstream (it was already presented).
  - KILL_NEXT=1 and acc=0 in the flush cycle: kill_pend<=1 (the wrong-path beat is still in flight upstream).
  - KILL_NEXT=1 and acc=1: kill_pend<=0 (the wrong-path beat has just been dropped).
  - KILL_NEXT=0: kill_pend stays 0.
- A flush while kill_pend=1 keeps kill_pend=1 unless acc=1.
- ZERO_BUBBLE=1: out_pc/out_inst = 0 whenever m_v=0, so a downstream decoder sees NOP 0x00000000 at pc 0.
- Steady streaming with out_ready=1: 1 beat/cycle, latency 1 cycle in_valid->out_valid, skid stays empty.
- Output stall: 1 extra beat is absorbed in skid. in_ready deasserts the cycle after skid fills and reasserts the cycle after out_ready returns.
- Widths: payload is copied verbatim; no arithmetic. occupancy never exceeds 2.

Test Plan:
- Stream: rst low 2 cycles then high. in_valid=1 with pc=0x100,0x104,0x108; out_ready=1 -> outputs 0x100,0x104,0x108 on consecutive cycles, each 1 cycle after input; occupancy=1; in_ready always 1.
- Backpressure: out_ready=0 while 0x200,0x204 are sent -> occupancy=2, in_ready=0, out_pc=0x200 held. Raise out_ready -> 0x200 then 0x204, in_ready=1 one cycle after out_ready.
- Flush full: occupancy=2 (0x300,0x304), pulse flush with in_valid=0 -> next cycle out_valid=0, out_pc=0, out_inst=0, kill_pend=1. Next beat 0x400 is accepted and dropped; then 0x500 appears at output; kill_pend=0.
- Flush with concurrent accept: flush=1 and in_valid=1 (0x600) in the same cycle -> 0x600 never appears, kill_pend=0; next beat 0x604 passes.
- KILL_NEXT=0 build: repeat scenario 3 -> kill_pend stays 0 and 0x400 appears at output.
- Async reset mid-stall: occupancy=2, drop rst between edges -> out_valid=0, outputs=0, in_ready=0 immediately. After release, in_ready=1 and the first new beat 0x700 is output 1 cycle later.
